// File: rtl/mt_fetch_sched_if.sv
// Fetch request bus between the thread scheduler and the fetch frontend.
// Parameter TID_W : thread-id width.
// Signals:
//   fetch_valid_o : fetch request for fetch_tid_o (scheduler -> frontend)
//   fetch_tid_o   : granted thread id             (scheduler -> frontend)
//   switch_o      : one-cycle pulse on thread change (scheduler -> frontend)
//   fetch_ready_i : frontend accepts a fetch this cycle (frontend -> scheduler)
interface mt_fetch_sched_if #(
   parameter int unsigned TID_W = 1
);
   logic             fetch_valid_o;
   logic [TID_W-1:0] fetch_tid_o;
   logic             switch_o;
   logic             fetch_ready_i;

   modport master (
      output fetch_valid_o,
      output fetch_tid_o,
      output switch_o,
      input  fetch_ready_i
   );

   modport slave (
      input  fetch_valid_o,
      input  fetch_tid_o,
      input  switch_o,
      output fetch_ready_i
   );
endinterface

// File: rtl/mt_fetch_sched.sv
// Round-robin fetch scheduler for a multithreaded frontend. One thread is
// granted at a time; it keeps the grant for QUANTUM accepted fetches or until
// it becomes ineligible, then a one-cycle DRAIN bubble precedes the new thread.
// Optional feature macro: MT_SCHED_SWITCH_ON_MISS_EN (an I-cache miss on the
// granted thread also requests rotation).
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   halt_i    : global fetch halt, forces IDLE
//   active_i  : per-thread enable
//   stall_i   : per-thread temporary stall
//   miss_i    : I-cache miss on the granted thread
//   fetch     : fetch bus (master side), see mt_fetch_sched_if
module mt_fetch_sched #(
   parameter int unsigned NUM_THREADS     = 2,
   parameter int unsigned NUM_THREADS_LOG = 1,
   parameter int unsigned QUANTUM         = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   halt_i,
   input  logic [NUM_THREADS-1:0] active_i,
   input  logic [NUM_THREADS-1:0] stall_i,
   input  logic                   miss_i,
   mt_fetch_sched_if.master       fetch
);

   localparam int unsigned CW = $clog2(QUANTUM + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                     state_q, state_d;
   logic [NUM_THREADS_LOG-1:0] cur_q, cur_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       valid_q, switch_q, switch_d;

   logic [NUM_THREADS-1:0]     eligible;
   logic [NUM_THREADS_LOG-1:0] pick, idx;
   logic                       any_found, other_found;
   logic                       accept, expire, miss_rot, rotate;

`ifdef MT_SCHED_SWITCH_ON_MISS_EN
   assign miss_rot = miss_i;
`else
   logic unused_miss;
   assign unused_miss = miss_i;
   assign miss_rot    = 1'b0;
`endif

   // Round-robin search from cur+1 upward with wrap; cur itself is checked last.
   always_comb begin
      eligible    = active_i & ~stall_i;
      pick        = cur_q;
      idx         = '0;
      any_found   = 1'b0;
      other_found = 1'b0;
      for (int k = int'(NUM_THREADS); k >= 1; k--) begin
         idx = NUM_THREADS_LOG'((int'(cur_q) + k) % int'(NUM_THREADS));
         if (eligible[idx]) begin
            pick      = idx;
            any_found = 1'b1;
            if (k != int'(NUM_THREADS)) other_found = 1'b1;
         end
      end
   end

   // Next-state logic; halt overrides everything and keeps cur.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      switch_d = 1'b0;
      accept   = (state_q == RUN) && fetch.fetch_ready_i;
      expire   = accept && (cnt_q == CW'(QUANTUM - 1));
      rotate   = !eligible[cur_q] || expire || miss_rot;

      case (state_q)
         IDLE: begin
            if (any_found) begin
               cur_d   = pick;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept && (cnt_q != CW'(QUANTUM))) cnt_d = cnt_q + CW'(1);
            if (rotate) begin
               if (other_found) begin
                  cur_d    = pick;
                  cnt_d    = '0;
                  switch_d = 1'b1;
                  state_d  = DRAIN;
               end else if (eligible[cur_q]) begin
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            state_d = eligible[cur_q] ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (halt_i) begin
         state_d  = IDLE;
         cur_d    = cur_q;
         cnt_d    = cnt_q;
         switch_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cur_q    <= NUM_THREADS_LOG'(NUM_THREADS - 1);
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         valid_q  <= (state_d == RUN);
         switch_q <= switch_d;
      end
   end

   assign fetch.fetch_valid_o = valid_q;
   assign fetch.fetch_tid_o   = cur_q;
   assign fetch.switch_o      = switch_q;

endmodule

// File: tb/tb_mt_fetch_sched.sv
// Scoreboard bench for mt_fetch_sched (NUM_THREADS=2, QUANTUM=4): each cycle
// the stimulus process applies inputs, advances a behavioural model of the
// scheduling rules and queues the expected outputs; a monitor pops and
// compares after every rising edge.
module tb_mt_fetch_sched;

   localparam int NT = 2;
   localparam int Q  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          halt;
   logic [NT-1:0] active;
   logic [NT-1:0] stall;
   logic          miss;

   mt_fetch_sched_if #(.TID_W(1)) fif ();

   mt_fetch_sched #(
      .NUM_THREADS     (NT),
      .NUM_THREADS_LOG (1),
      .QUANTUM         (Q)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .halt_i   (halt),
      .active_i (active),
      .stall_i  (stall),
      .miss_i   (miss),
      .fetch    (fif)
   );

   always #5 clk = ~clk;

`ifdef MT_SCHED_SWITCH_ON_MISS_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {valid, tid, switch} after each rising edge.
   logic [2:0] exp_q[$];

   // Model: mode 0 = not fetching, 1 = fetching, 2 = one-cycle bubble.
   int m_mode  = 0;
   int m_cur   = NT - 1;
   int m_count = 0;
   bit m_sw    = 1'b0;

   // First eligible thread after cur (wrapping); cur itself optionally last.
   function automatic int next_thread(input int cur, input logic [NT-1:0] el,
                                      input bit allow_self);
      for (int k = 1; k <= NT; k++) begin
         int t;
         t = (cur + k) % NT;
         if (k == NT && !allow_self) return -1;
         if (el[t]) return t;
      end
      return -1;
   endfunction

   task automatic model_step(input bit r, input bit h, input logic [NT-1:0] a,
                             input logic [NT-1:0] s, input bit m, input bit rdy);
      logic [NT-1:0] el;
      int            p;
      bit            give_up;
      el = a & ~s;
      m_sw = 1'b0;
      if (!r) begin
         m_mode = 0; m_cur = NT - 1; m_count = 0;
      end else if (h) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         p = next_thread(m_cur, el, 1'b1);
         if (p >= 0) begin m_cur = p; m_count = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
         if (rdy) m_count = m_count + 1;
         give_up = !el[m_cur] || (rdy && m_count == Q) || (MISS_EN && m);
         if (give_up) begin
            p = next_thread(m_cur, el, 1'b0);
            if (p >= 0) begin
               m_cur = p; m_count = 0; m_sw = 1'b1; m_mode = 2;
            end else if (el[m_cur]) begin
               m_count = 0;
            end else begin
               m_mode = 0;
            end
         end
      end else begin
         m_mode = el[m_cur] ? 1 : 0;
      end
      exp_q.push_back({(m_mode == 1), 1'(m_cur), m_sw});
   endtask

   task automatic drive(input bit r, input bit h, input logic [NT-1:0] a,
                        input logic [NT-1:0] s, input bit m, input bit rdy,
                        input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n = r; halt = h; active = a; stall = s; miss = m;
         fif.fetch_ready_i = rdy;
         model_step(r, h, a, s, m, rdy);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation.
   always @(posedge clk) begin
      logic [2:0] e, got;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {fif.fetch_valid_o, fif.fetch_tid_o, fif.switch_o};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL outputs @%0t: got valid=%b tid=%0d switch=%b, expected valid=%b tid=%0d switch=%b",
                     $time, got[2], got[1], got[0], e[2], e[1], e[0]);
         end
      end
   end

   initial begin
      rst_n = 1'b0; halt = 1'b0; active = '0; stall = '0; miss = 1'b0;
      fif.fetch_ready_i = 1'b0;

      drive(0, 0, 2'b11, 2'b00, 0, 1, 3);   // reset state
      drive(1, 0, 2'b11, 2'b00, 0, 1, 22);  // alternating quanta with bubbles
      drive(0, 0, 2'b01, 2'b00, 0, 1, 1);
      drive(1, 0, 2'b01, 2'b00, 0, 1, 14);  // single thread, no switch
      drive(0, 0, 2'b11, 2'b00, 0, 1, 1);
      drive(1, 0, 2'b11, 2'b00, 0, 1, 3);   // idle + 2 fetches
      drive(1, 0, 2'b11, 2'b01, 0, 1, 4);   // stall cur -> switch to 1
      drive(1, 0, 2'b11, 2'b11, 0, 1, 3);   // both stalled -> idle
      drive(1, 0, 2'b11, 2'b00, 0, 1, 2);
      drive(1, 0, 2'b11, 2'b00, 0, 0, 10);  // ready low: frozen
      drive(1, 0, 2'b11, 2'b00, 0, 1, 8);
      drive(0, 0, 2'b11, 2'b00, 0, 1, 1);
      drive(1, 0, 2'b11, 2'b00, 0, 1, 5);   // reaches bubble
      drive(1, 1, 2'b11, 2'b00, 0, 1, 3);   // halt
      drive(1, 0, 2'b11, 2'b00, 0, 1, 4);
      drive(1, 0, 2'b11, 2'b00, 1, 1, 1);   // miss
      drive(1, 0, 2'b11, 2'b00, 0, 1, 6);
      drive(1, 0, 2'b11, 2'b00, 0, 1, 2);
      drive(0, 0, 2'b11, 2'b00, 0, 1, 1);   // reset mid-run
      drive(1, 0, 2'b11, 2'b00, 0, 1, 3);

      for (int i = 0; i < 3000; i++) begin
         bit r, h, m, rdy;
         logic [NT-1:0] a, s;
         r   = ($urandom_range(0, 199) != 0);
         h   = ($urandom_range(0, 29) == 0);
         m   = ($urandom_range(0, 7) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         a   = ($urandom_range(0, 5) == 0) ? NT'($urandom) : '1;
         s   = ($urandom_range(0, 4) == 0) ? NT'($urandom) : '0;
         drive(r, h, a, s, m, rdy, 1);
      end

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
